// File: rtl/stream_pkg.sv
// Shared helpers for the stream width converters: lane counter width,
// out_din field offsets and the thermometer lane mask.
package stream_pkg;

  localparam int unsigned MAX_RATIO = 64;

  function automatic int unsigned lane_cnt_width(input int unsigned ratio);
    return $clog2(ratio);
  endfunction

  // Bit position of the last flag in {last, lane_mask, data}.
  function automatic int unsigned last_bit(input int unsigned out_width,
                                           input int unsigned ratio);
    return out_width + ratio;
  endfunction

  function automatic int unsigned mask_lsb(input int unsigned out_width);
    return out_width;
  endfunction

  // Thermometer mask with bits [cnt:0] set; callers slice to their ratio.
  function automatic logic [MAX_RATIO-1:0] lane_mask(input int unsigned cnt);
    logic [MAX_RATIO-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_RATIO; i++) begin
      m[i] = (i <= cnt);
    end
    return m;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry output holding register with valid/full_n handshake;
// a new word may be loaded in the same cycle the held one drains.
module stream_out_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_full_n,
  output logic             ready_c,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  // Room for a new word when empty or when the held word leaves this cycle.
  assign ready_c = ~out_valid | out_full_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (load) begin
      out_valid <= 1'b1;
      out_data  <= load_data;
    end else if (out_full_n) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_width_upsizer.sv
// Packs RATIO narrow FWFT words into one wide word (lane 0 first); a last
// flag flushes a partial word early with a lane mask of the valid lanes.
module stream_width_upsizer
  import stream_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned RATIO     = 4,
  parameter int unsigned OUT_WIDTH = IN_WIDTH * RATIO
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_empty_n,
  output logic                           in_read,
  input  logic [IN_WIDTH:0]              in_dout,
  input  logic                           out_full_n,
  output logic                           out_write,
  output logic [OUT_WIDTH+RATIO:0]       out_din,
  output logic [$clog2(RATIO)-1:0]       pending_lanes
);

  localparam int unsigned CW       = lane_cnt_width(RATIO);
  localparam int unsigned DW       = OUT_WIDTH + RATIO + 1;
  localparam int unsigned LAST_BIT = last_bit(OUT_WIDTH, RATIO);
  localparam int unsigned MASK_LSB = mask_lsb(OUT_WIDTH);

  logic [OUT_WIDTH-1:0] acc;
  logic [OUT_WIDTH-1:0] acc_merged_c;
  logic [OUT_WIDTH-1:0] word_c;
  logic [CW-1:0]        cnt;
  logic [IN_WIDTH-1:0]  payload_c;
  logic                 last_c;
  logic                 ready_c;
  logic                 accept_c;
  logic                 complete_c;
  logic [RATIO-1:0]     mask_c;
  logic [DW-1:0]        load_word_c;
  logic [DW-1:0]        out_word;
  logic                 out_valid;

  assign payload_c  = in_dout[IN_WIDTH-1:0];
  assign last_c     = in_dout[IN_WIDTH];
  assign accept_c   = ready_c & in_empty_n;
  assign complete_c = accept_c & (last_c | (cnt == CW'(RATIO - 1)));

  // Current lane takes the payload; lanes above cnt are forced to zero.
  always_comb begin
    acc_merged_c = acc;
    word_c       = '0;
    for (int unsigned i = 0; i < RATIO; i++) begin
      if (CW'(i) == cnt) begin
        acc_merged_c[i*IN_WIDTH +: IN_WIDTH] = payload_c;
      end
      if (i <= 32'(cnt)) begin
        word_c[i*IN_WIDTH +: IN_WIDTH] = acc_merged_c[i*IN_WIDTH +: IN_WIDTH];
      end
    end
  end

  assign mask_c = RATIO'(lane_mask(32'(cnt)));

  always_comb begin
    load_word_c                      = '0;
    load_word_c[OUT_WIDTH-1:0]       = word_c;
    load_word_c[MASK_LSB +: RATIO]   = mask_c;
    load_word_c[LAST_BIT]            = last_c;
  end

  // Accumulator and lane counter; counter wraps only through completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete_c) begin
      acc <= '0;
      cnt <= '0;
    end else if (accept_c) begin
      acc <= acc_merged_c;
      cnt <= cnt + 1'b1;
    end
  end

  stream_out_reg #(
    .WIDTH (DW)
  ) u_out_reg (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (complete_c),
    .load_data  (load_word_c),
    .out_full_n (out_full_n),
    .ready_c    (ready_c),
    .out_valid  (out_valid),
    .out_data   (out_word)
  );

  assign in_read       = ready_c;
  assign out_write     = out_valid;
  assign out_din       = out_word;
  assign pending_lanes = cnt;

endmodule

// File: tb/tb_stream_width_upsizer.sv
// Randomized bench for stream_width_upsizer against a queue-based packing model.
module tb_stream_width_upsizer;

  localparam int unsigned IN_W  = 32;
  localparam int unsigned RATIO = 4;
  localparam int unsigned OUT_W = IN_W * RATIO;
  localparam int unsigned OUTD  = OUT_W + RATIO + 1;
  localparam int unsigned CW    = $clog2(RATIO);

  logic            clk;
  logic            reset_n;
  logic            in_empty_n;
  logic            in_read;
  logic [IN_W:0]   in_dout;
  logic            out_full_n;
  logic            out_write;
  logic [OUTD-1:0] out_din;
  logic [CW-1:0]   pending_lanes;

  stream_width_upsizer #(
    .IN_WIDTH (IN_W),
    .RATIO    (RATIO)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .in_empty_n    (in_empty_n),
    .in_read       (in_read),
    .in_dout       (in_dout),
    .out_full_n    (out_full_n),
    .out_write     (out_write),
    .out_din       (out_din),
    .pending_lanes (pending_lanes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int dut_writes = 0;
  int last_wr = -1;
  int valid_pct = 100;
  int ready_pct = 100;
  int stall_cycles = 0;
  bit track_gap = 1'b0;

  // Reference model: narrow words of the open wide word, and wide words
  // completed but not yet taken by the downstream side (head = on the bus).
  logic [IN_W-1:0] part[$];
  logic [OUTD-1:0] outq[$];

  task automatic chk(input string tag, input logic [OUTD-1:0] obs,
                     input logic [OUTD-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, check outputs against the model, advance both.
  task automatic cycle(input bit en, input bit lst, input logic [IN_W-1:0] pl,
                       input bit fn, output bit accepted);
    bit exp_valid;
    bit exp_rd;
    logic [OUT_W-1:0] d;
    logic [RATIO-1:0] m;
    in_empty_n = en;
    in_dout    = {lst, pl};
    out_full_n = fn;
    #1;
    exp_valid = (outq.size() > 0);
    exp_rd    = !exp_valid || fn;
    chk("in_read", OUTD'(in_read), OUTD'(exp_rd));
    chk("out_write", OUTD'(out_write), OUTD'(exp_valid));
    if (exp_valid) chk("out_din", out_din, outq[0]);
    chk("pending_lanes", OUTD'(pending_lanes), OUTD'(part.size()));
    if (out_write && fn) begin
      if (track_gap && last_wr >= 0) chk("write_gap", OUTD'(cyc - last_wr), OUTD'(4));
      last_wr = cyc;
      dut_writes++;
    end
    if (exp_valid && fn) void'(outq.pop_front());
    accepted = exp_rd && en;
    if (accepted) begin
      part.push_back(pl);
      if (lst || part.size() == RATIO) begin
        d = '0;
        for (int i = 0; i < part.size(); i++) d = d | (OUT_W'(part[i]) << (IN_W * i));
        m = RATIO'((1 << part.size()) - 1);
        outq.push_back({lst, m, d});
        part.delete();
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one word (FWFT: held until popped) under random bubbles/stalls.
  task automatic send(input logic [IN_W-1:0] pl, input bit lst);
    bit acc;
    bit en;
    bit fn;
    int guard;
    acc = 1'b0;
    guard = 0;
    while (!acc) begin
      en = ($urandom_range(99) < valid_pct);
      fn = (stall_cycles > 0) ? 1'b0 : ($urandom_range(99) < ready_pct);
      if (stall_cycles > 0) stall_cycles--;
      cycle(en, lst, pl, fn, acc);
      guard++;
      if (!acc && guard > 500) begin
        checks++;
        errors++;
        $error("FAIL send_timeout observed=not_accepted expected=accepted");
        return;
      end
    end
  endtask

  task automatic drain();
    bit acc;
    int guard;
    guard = 0;
    while (outq.size() > 0 && guard < 50) begin
      cycle(1'b0, 1'b0, '0, 1'b1, acc);
      guard++;
    end
    if (outq.size() > 0) begin
      checks++;
      errors++;
      $error("FAIL drain_timeout observed=%0d expected=0", outq.size());
    end
    cycle(1'b0, 1'b0, '0, 1'b1, acc);
  endtask

  initial begin
    reset_n    = 1'b0;
    in_empty_n = 1'b0;
    in_dout    = '0;
    out_full_n = 1'b1;
    #12;
    chk("rst_in_read", OUTD'(in_read), OUTD'(1));
    chk("rst_out_write", OUTD'(out_write), OUTD'(0));
    chk("rst_pending", OUTD'(pending_lanes), OUTD'(0));
    chk("rst_out_din", out_din, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Full word back-to-back
    send(32'h11, 1'b0);
    send(32'h22, 1'b0);
    send(32'h33, 1'b0);
    send(32'h44, 1'b0);
    chk("full_write", OUTD'(out_write), OUTD'(1));
    chk("full_word", out_din,
        {1'b0, 4'b1111, 32'h44, 32'h33, 32'h22, 32'h11});
    drain();

    // Partial flush
    send(32'hA0, 1'b0);
    send(32'hA1, 1'b1);
    chk("partial_word", out_din, {1'b1, 4'b0011, 64'h0, 32'hA1, 32'hA0});
    chk("partial_pending", OUTD'(pending_lanes), OUTD'(0));
    drain();

    // Backpressure: hold the first wide word while more input arrives
    for (int i = 0; i < 4; i++) send(32'hB000_0000 + 32'(i), 1'b0);
    stall_cycles = 10;
    for (int i = 0; i < 8; i++) send(32'hC000_0000 + 32'(i), 1'b0);
    stall_cycles = 0;
    drain();

    // Streaming at full rate: one write every RATIO cycles
    dut_writes = 0;
    last_wr = -1;
    track_gap = 1'b1;
    for (int i = 0; i < 64; i++) send($urandom, 1'b0);
    drain();
    track_gap = 1'b0;
    chk("stream_writes", OUTD'(dut_writes), OUTD'(16));

    // Bubbles, random stalls and random early flushes
    valid_pct = 50;
    ready_pct = 60;
    for (int i = 0; i < 40; i++) send($urandom, ($urandom_range(4) == 0));
    send(32'h77, 1'b1);
    send(32'h5, 1'b1);
    chk("lone_last", out_din, {1'b1, 4'b0001, 96'h0, 32'h5});
    drain();

    // Asynchronous reset in the middle of a word
    valid_pct = 100;
    ready_pct = 100;
    send(32'hDEAD_0001, 1'b0);
    send(32'hDEAD_0002, 1'b0);
    in_empty_n = 1'b0;
    chk("pre_rst_pending", OUTD'(pending_lanes), OUTD'(2));
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_in_read", OUTD'(in_read), OUTD'(1));
    chk("async_out_write", OUTD'(out_write), OUTD'(0));
    chk("async_pending", OUTD'(pending_lanes), OUTD'(0));
    chk("async_out_din", out_din, '0);
    #2;
    reset_n = 1'b1;
    part.delete();
    outq.delete();
    send(32'hC0, 1'b0);
    send(32'hC1, 1'b0);
    send(32'hC2, 1'b0);
    send(32'hC3, 1'b0);
    chk("post_rst_word", out_din,
        {1'b0, 4'b1111, 32'hC3, 32'hC2, 32'hC1, 32'hC0});
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
